// File: rtl/div_pkg.sv
// div_pkg: shared FSM state, op codes and op classification for seq_div.
// Op codes come from the `ALU_* macros; defaults are provided when absent.
`ifndef ALU_DIV
`define ALU_DIV 5'd16
`endif
`ifndef ALU_DIVU
`define ALU_DIVU 5'd17
`endif
`ifndef ALU_REM
`define ALU_REM 5'd18
`endif
`ifndef ALU_REMU
`define ALU_REMU 5'd19
`endif

package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } div_state_t;

    typedef struct packed {
        logic valid;
        logic sgn;
        logic rem;
    } op_class_t;

    localparam logic [4:0] OP_DIV  = `ALU_DIV;
    localparam logic [4:0] OP_DIVU = `ALU_DIVU;
    localparam logic [4:0] OP_REM  = `ALU_REM;
    localparam logic [4:0] OP_REMU = `ALU_REMU;

    function automatic op_class_t classify(input logic [4:0] op);
        op_class_t c;
        c = '0;
        case (op)
            `ALU_DIV:  c = '{valid: 1'b1, sgn: 1'b1, rem: 1'b0};
            `ALU_DIVU: c = '{valid: 1'b1, sgn: 1'b0, rem: 1'b0};
            `ALU_REM:  c = '{valid: 1'b1, sgn: 1'b1, rem: 1'b1};
            `ALU_REMU: c = '{valid: 1'b1, sgn: 1'b0, rem: 1'b1};
            default:   c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/div_step.sv
// div_step: BITS_PER_CYCLE chained restoring-division steps.
// Dividend slice is consumed MSB first; remainder is WIDTH+1 bits.
module div_step #(
    parameter int WIDTH = 32,
    parameter int BPC   = 1
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [BPC-1:0]   slice,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic [BPC-1:0]   qbits
);

    logic [WIDTH:0] dext;
    assign dext = {1'b0, divisor};

    // Shift in one dividend bit per step, subtract when it fits.
    always_comb begin
        logic [WIDTH:0] r;
        r     = rem_in;
        qbits = '0;
        for (int i = BPC - 1; i >= 0; i--) begin
            r = {r[WIDTH-1:0], slice[i]};
            if (r >= dext) begin
                r        = r - dext;
                qbits[i] = 1'b1;
            end
        end
        rem_out = r;
    end

endmodule

// File: rtl/seq_div.sv
// seq_div: iterative DIV/DIVU/REM/REMU unit with start/busy/done handshake.
// Optional DIV_REM_FUSE_EN returns the sibling result of a repeated op.
module seq_div
    import div_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       ALUCtrl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t state, nstate;

    logic [WIDTH-1:0] dvd, dsr, quot, res_q;
    logic [WIDTH:0]   rem, rem_n;
    logic [CW-1:0]    cnt;
    logic [BITS_PER_CYCLE-1:0] qbits;
    logic op_valid, op_rem, signa, signb, special;

    op_class_t cls;
    logic a_neg, b_neg, div0, ovf, hit, take_fix;
    logic [WIDTH-1:0] amag, bmag, spec_val;
    logic [WIDTH-1:0] qres, rres, fix_val;

    assign cls   = classify(ALUCtrl);
    assign a_neg = cls.sgn & A[WIDTH-1];
    assign b_neg = cls.sgn & B[WIDTH-1];
    assign amag  = a_neg ? (0 - A) : A;
    assign bmag  = b_neg ? (0 - B) : B;
    assign div0  = (B == '0);
    assign ovf   = cls.sgn && (A == MIN) && (B == '1);

`ifdef DIV_REM_FUSE_EN
    logic [WIDTH-1:0] fa, fb, fq, fr, ra, rb;
    logic fsgn, fvalid, rsgn;
    assign hit = fvalid && cls.valid && (A == fa) && (B == fb)
                 && (cls.sgn == fsgn);
`else
    assign hit = 1'b0;
`endif

    assign take_fix = div0 | ovf | hit;

    // Result for ops that bypass CALC, chosen at accept time.
    always_comb begin
        spec_val = '0;
        if (!cls.valid) begin
            spec_val = '0;
        end else if (div0) begin
            spec_val = cls.rem ? A : '1;
        end else if (ovf) begin
            spec_val = cls.rem ? '0 : MIN;
`ifdef DIV_REM_FUSE_EN
        end else if (hit) begin
            spec_val = cls.rem ? fr : fq;
`endif
        end
    end

    div_step #(.WIDTH(WIDTH), .BPC(BITS_PER_CYCLE)) u_step (
        .rem_in  (rem),
        .slice   (dvd[WIDTH-1 -: BITS_PER_CYCLE]),
        .divisor (dsr),
        .rem_out (rem_n),
        .qbits   (qbits)
    );

    assign qres = (signa ^ signb) ? (0 - quot) : quot;
    assign rres = signa ? (0 - rem[WIDTH-1:0]) : rem[WIDTH-1:0];

    // Final value presented in FIX: bypass value, or sign-fixed q/r.
    always_comb begin
        fix_val = '0;
        if (special)       fix_val = quot;
        else if (!op_valid) fix_val = '0;
        else if (op_rem)   fix_val = rres;
        else               fix_val = qres;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    // Next state; flush wins over everything.
    always_comb begin
        nstate = state;
        if (flush) begin
            nstate = IDLE;
        end else begin
            unique case (state)
                IDLE: if (start) nstate = take_fix ? FIX : CALC;
                CALC: if (cnt == CW'(1)) nstate = FIX;
                FIX:  nstate = IDLE;
                default: nstate = IDLE;
            endcase
        end
    end

    // Handshake outputs; result is live in FIX, held afterwards.
    always_comb begin
        busy   = (state != IDLE);
        done   = (state == FIX);
        result = (state == FIX) ? fix_val : res_q;
    end

    // Datapath: operand capture, iteration, result hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd      <= '0;
            dsr      <= '0;
            quot     <= '0;
            rem      <= '0;
            cnt      <= '0;
            res_q    <= '0;
            op_valid <= 1'b0;
            op_rem   <= 1'b0;
            signa    <= 1'b0;
            signb    <= 1'b0;
            special  <= 1'b0;
        end else if (!flush) begin
            unique case (state)
                IDLE: if (start) begin
                    op_valid <= cls.valid;
                    op_rem   <= cls.rem;
                    signa    <= a_neg;
                    signb    <= b_neg;
                    dvd      <= amag;
                    dsr      <= bmag;
                    rem      <= '0;
                    cnt      <= CW'(N);
                    special  <= take_fix;
                    quot     <= take_fix ? spec_val : '0;
                end
                CALC: begin
                    rem  <= rem_n;
                    dvd  <= dvd << BITS_PER_CYCLE;
                    quot <= (quot << BITS_PER_CYCLE)
                            | {{(WIDTH-BITS_PER_CYCLE){1'b0}}, qbits};
                    cnt  <= cnt - CW'(1);
                end
                FIX: res_q <= fix_val;
                default: ;
            endcase
        end
    end

`ifdef DIV_REM_FUSE_EN
    // Saved operand/result pair for DIV<->REM fusion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fa     <= '0;
            fb     <= '0;
            fq     <= '0;
            fr     <= '0;
            ra     <= '0;
            rb     <= '0;
            fsgn   <= 1'b0;
            rsgn   <= 1'b0;
            fvalid <= 1'b0;
        end else if (flush) begin
            fvalid <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                ra   <= A;
                rb   <= B;
                rsgn <= cls.sgn;
                if (div0 || ovf) fvalid <= 1'b0;
            end
            if (state == FIX && !special && op_valid) begin
                fa     <= ra;
                fb     <= rb;
                fsgn   <= rsgn;
                fq     <= qres;
                fr     <= rres;
                fvalid <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: directed checks of seq_div (1 and 4 bits per cycle).
// Define DIV_REM_FUSE_EN to check the fused-result latency too.
module tb_seq_div;
    import div_pkg::*;

    localparam int W = 32;
`ifdef DIV_REM_FUSE_EN
    localparam bit FUSE = 1'b1;
`else
    localparam bit FUSE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start4 = 1'b0;
    logic flush = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [4:0] op = '0;
    logic busy, done, busy4, done4;
    logic [W-1:0] result, result4;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_div #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush),
        .A(a), .B(b), .ALUCtrl(op),
        .busy(busy), .done(done), .result(result)
    );

    seq_div #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .flush(flush),
        .A(a), .B(b), .ALUCtrl(op),
        .busy(busy4), .done(done4), .result(result4)
    );

    // Issue one op and wait (bounded) for done; lat=-1 on timeout.
    task automatic run(input bit w4, input logic [4:0] o,
                       input logic [W-1:0] x, input logic [W-1:0] y,
                       output int lat, output logic [W-1:0] res);
        @(posedge clk);
        @(negedge clk);
        op = o; a = x; b = y;
        if (w4) start4 = 1'b1;
        else    start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start4 = 1'b0;
        a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; op = 5'd31;
        lat = -1; res = '0;
        for (int c = 1; c <= 100; c++) begin
            if (w4 ? done4 : done) begin
                lat = c;
                res = w4 ? result4 : result;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
            n_fail++;
            $display("FAIL reset: busy=%b done=%b result=%h want 0 0 0",
                     busy, done, result);
        end
        n_chk++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || result4 !== '0) begin
            n_fail++;
            $display("FAIL reset4: busy=%b done=%b result=%h want 0 0 0",
                     busy4, done4, result4);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_signed;
        int lat;
        logic [W-1:0] r;
        run(0, OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, r);
        n_chk++;
        if (r !== 32'hFFFF_FFFD || lat !== 33) begin
            n_fail++;
            $display("FAIL div_neg7_2: got %h @%0d want fffffffd @33", r, lat);
        end
        run(0, OP_REM, 32'hFFFF_FFF9, 32'd2, lat, r);
        n_chk++;
        if (r !== 32'hFFFF_FFFF || lat !== (FUSE ? 1 : 33)) begin
            n_fail++;
            $display("FAIL rem_neg7_2: got %h @%0d want ffffffff @%0d",
                     r, lat, FUSE ? 1 : 33);
        end
        run(0, OP_DIV, 32'd100, 32'hFFFF_FFF9, lat, r);
        n_chk++;
        if (r !== 32'hFFFF_FFF2 || lat !== 33) begin
            n_fail++;
            $display("FAIL div_100_neg7: got %h @%0d want fffffff2 @33", r, lat);
        end
        run(0, OP_REM, 32'd100, 32'hFFFF_FFF9, lat, r);
        n_chk++;
        if (r !== 32'd2) begin
            n_fail++;
            $display("FAIL rem_100_neg7: got %h want 00000002", r);
        end
    endtask

    task automatic test_unsigned;
        int lat;
        logic [W-1:0] r;
        run(0, OP_DIVU, 32'hFFFF_FFFF, 32'h10, lat, r);
        n_chk++;
        if (r !== 32'h0FFF_FFFF || lat !== 33) begin
            n_fail++;
            $display("FAIL divu: got %h @%0d want 0fffffff @33", r, lat);
        end
        run(0, OP_REMU, 32'hFFFF_FFFF, 32'h10, lat, r);
        n_chk++;
        if (r !== 32'hF) begin
            n_fail++;
            $display("FAIL remu: got %h want 0000000f", r);
        end
        run(1, OP_DIVU, 32'hFFFF_FFFF, 32'h10, lat, r);
        n_chk++;
        if (r !== 32'h0FFF_FFFF || lat !== 9) begin
            n_fail++;
            $display("FAIL divu_bpc4: got %h @%0d want 0fffffff @9", r, lat);
        end
        run(1, OP_REMU, 32'hFFFF_FFFF, 32'h10, lat, r);
        n_chk++;
        if (r !== 32'hF || lat !== (FUSE ? 1 : 9)) begin
            n_fail++;
            $display("FAIL remu_bpc4: got %h @%0d want 0000000f @%0d",
                     r, lat, FUSE ? 1 : 9);
        end
    endtask

    task automatic test_special;
        int lat;
        logic [W-1:0] r;
        run(0, OP_DIV, 32'd5, 32'd0, lat, r);
        n_chk++;
        if (r !== 32'hFFFF_FFFF || lat !== 1) begin
            n_fail++;
            $display("FAIL div_by0: got %h @%0d want ffffffff @1", r, lat);
        end
        run(0, OP_REMU, 32'h1234, 32'd0, lat, r);
        n_chk++;
        if (r !== 32'h1234 || lat !== 1) begin
            n_fail++;
            $display("FAIL remu_by0: got %h @%0d want 00001234 @1", r, lat);
        end
        run(0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, r);
        n_chk++;
        if (r !== 32'h8000_0000 || lat !== 1) begin
            n_fail++;
            $display("FAIL div_ovf: got %h @%0d want 80000000 @1", r, lat);
        end
        run(0, OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, lat, r);
        n_chk++;
        if (r !== 32'h0 || lat !== 1) begin
            n_fail++;
            $display("FAIL rem_ovf: got %h @%0d want 00000000 @1", r, lat);
        end
    endtask

    task automatic test_unknown_op;
        int lat;
        logic [W-1:0] r;
        run(0, 5'd0, 32'd10, 32'd3, lat, r);
        n_chk++;
        if (r !== 32'h0 || lat !== 33) begin
            n_fail++;
            $display("FAIL unknown_op: got %h @%0d want 00000000 @33", r, lat);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        logic [W-1:0] r;
        @(posedge clk);
        @(negedge clk);
        op = OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; r = '0;
        for (int c = 1; c <= 100; c++) begin
            if (c == 5) begin
                op = OP_REMU; a = 32'd1000; b = 32'd3; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                lat = c;
                r = result;
                break;
            end
            @(posedge clk); #1;
        end
        n_chk++;
        if (r !== 32'd14 || lat !== 33) begin
            n_fail++;
            $display("FAIL start_while_busy: got %h @%0d want 0000000e @33",
                     r, lat);
        end
        op = OP_DIVU; a = 32'd50; b = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_chk++;
        if (busy !== 1'b0 || result !== 32'd14) begin
            n_fail++;
            $display("FAIL start_on_done: busy=%b result=%h want 0 0000000e",
                     busy, result);
        end
    endtask

    task automatic test_flush;
        bit saw_done;
        @(posedge clk);
        @(negedge clk);
        op = OP_DIVU; a = 32'hFFFF_FFFF; b = 32'h10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_chk++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd14) begin
            n_fail++;
            $display("FAIL flush: busy=%b done=%b result=%h want 0 0 0000000e",
                     busy, done, result);
        end
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        n_chk++;
        if (saw_done !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_no_done: done seen=%b want 0", saw_done);
        end
    endtask

    task automatic test_reset_mid;
        @(posedge clk);
        @(negedge clk);
        op = OP_DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_chk++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b done=%b result=%h want 0 0 0",
                     busy, done, result);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fuse;
        int lat;
        logic [W-1:0] r;
        run(0, OP_DIV, 32'd100, 32'd7, lat, r);
        n_chk++;
        if (r !== 32'd14 || lat !== 33) begin
            n_fail++;
            $display("FAIL fuse_div: got %h @%0d want 0000000e @33", r, lat);
        end
        run(0, OP_REM, 32'd100, 32'd7, lat, r);
        n_chk++;
        if (r !== 32'd2 || lat !== (FUSE ? 1 : 33)) begin
            n_fail++;
            $display("FAIL fuse_rem: got %h @%0d want 00000002 @%0d",
                     r, lat, FUSE ? 1 : 33);
        end
        run(0, OP_REM, 32'd100, 32'd8, lat, r);
        n_chk++;
        if (r !== 32'd4 || lat !== 33) begin
            n_fail++;
            $display("FAIL fuse_miss: got %h @%0d want 00000004 @33", r, lat);
        end
    endtask

    initial begin
        test_reset();
        test_signed();
        test_unsigned();
        test_special();
        test_unknown_op();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_fuse();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
